// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS execution controller: FSM states and mode-switch values.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_BRK  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_STEP = 2'd1,
        MODE_RUN  = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    // Both free-running modes share the S_RUN state.
    function automatic logic is_free_mode(input mode_e m);
        return (m == MODE_RUN) || (m == MODE_FAST);
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stable-count filter and a one-cycle pulse
// on each debounced rising edge.
module step_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any cycle where the input agrees with the level restarts the count.
        if (sync_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync_q;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync_q  <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// Execution controller for the MIPS core: issues one-cycle clock enables in halt,
// single-step, prescaled-run or full-rate mode, with a sticky break state.
module mips_step_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       mode_i,
    input  logic             step_btn_i,
    input  logic             brk_i,
    output logic             cpu_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             tick_o
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0]       mode_meta_q;
    mode_e            mode_s_q;
    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             tick_q, tick_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;

    step_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_debounce (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .btn_i  (step_btn_i),
        .press_o(press)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALT: begin
                if (mode_s_q == MODE_STEP)   state_d = S_STEP;
                else if (is_free_mode(mode_s_q)) state_d = S_RUN;
            end
            S_STEP, S_RUN: begin
                if (brk_i)                       state_d = S_BRK;
                else if (mode_s_q == MODE_HALT)  state_d = S_HALT;
                else if (mode_s_q == MODE_STEP)  state_d = S_STEP;
                else                             state_d = S_RUN;
            end
            S_BRK: begin
                if (mode_s_q == MODE_HALT) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase

        // A sampled break suppresses any enable, even a coinciding press or tick.
        cpu_en_d = 1'b0;
        if (!brk_i) begin
            if (state_q == S_STEP) begin
                cpu_en_d = press;
            end else if (state_q == S_RUN) begin
                cpu_en_d = (mode_s_q == MODE_FAST) || ((mode_s_q == MODE_RUN) && tick_q);
            end
        end

        tick_d  = (state_q == S_RUN) && (presc_q == PRESC_LAST);
        presc_d = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN) && (presc_q != PRESC_LAST)) begin
            presc_d = presc_q + 1'b1;
        end

        cnt_d = cnt_q + CNT_W'(cpu_en_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_meta_q <= 2'b00;
            mode_s_q    <= MODE_HALT;
            state_q     <= S_HALT;
            cpu_en_q    <= 1'b0;
            tick_q      <= 1'b0;
            presc_q     <= '0;
            cnt_q       <= '0;
        end else begin
            mode_meta_q <= mode_i;
            mode_s_q    <= mode_e'(mode_meta_q);
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            tick_q      <= tick_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_en_o    = cpu_en_q;
    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;
    assign tick_o      = tick_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Scoreboard bench for mips_step_ctrl: scenarios predict enable cycles and counter
// values; a negedge monitor matches every cpu_en_o pulse against the queue.
module tb_mips_step_ctrl;

    localparam int TD = 8;
    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_i, step_btn_i, brk_i;
    logic [1:0]    mode_i;
    logic          cpu_en_o, tick_o;
    logic [1:0]    state_o;
    logic [CW-1:0] instr_cnt_o;

    mips_step_ctrl #(
        .TICK_DIV  (TD),
        .DEB_CYCLES(DB),
        .CNT_W     (CW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .mode_i     (mode_i),
        .step_btn_i (step_btn_i),
        .brk_i      (brk_i),
        .cpu_en_o   (cpu_en_o),
        .state_o    (state_o),
        .instr_cnt_o(instr_cnt_o),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected enable at the given edge, carrying the counter value it should see.
    task automatic push_en(input int c);
        exp_t e;
        e.cyc = c;
        e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic tick_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_en_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_enable: cpu_en_o=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                chk("enable_cycle", cyc, e.cyc);
                chk("enable_instr_cnt", int'(instr_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e, m, r, b, h, t, q, len, k_pulses, np;

        reset_i    = 1'b1;
        mode_i     = 2'b00;
        step_btn_i = 1'b0;
        brk_i      = 1'b0;
        tick_to(3);
        @(negedge clk);
        chk("reset_cpu_en", int'(cpu_en_o), 0);
        chk("reset_state", int'(state_o), 0);
        chk("reset_instr_cnt", int'(instr_cnt_o), 0);
        chk("reset_tick", int'(tick_o), 0);
        reset_i = 1'b0;

        // HALT: nothing issues, and a button press here must be discarded.
        n = cyc;
        tick_to(n + 5 + $urandom_range(0, 5));
        step_btn_i = 1'b1;
        tick_to(cyc + 15);
        step_btn_i = 1'b0;
        tick_to(n + 50 + $urandom_range(0, 10));
        @(negedge clk);
        chk("halt_state", int'(state_o), 0);
        chk("halt_instr_cnt", int'(instr_cnt_o), 0);

        // RUN: first pulse TD+1 after entry, then one every TD; 20 pulses.
        n = cyc;
        mode_i = 2'b10;
        e = n + 3;
        for (int k = 1; k <= 20; k++) push_en(e + 1 + TD * k);
        tick_to(n + 2);
        @(negedge clk);
        chk("run_latency_before", int'(state_o), 0);
        tick_to(n + 3);
        @(negedge clk);
        chk("run_entry_state", int'(state_o), 2);
        tick_to(e + TD);
        @(negedge clk);
        chk("run_first_tick", int'(tick_o), 1);
        m = e + TD * 20 + 1;
        tick_to(m);
        mode_i = 2'b01;
        tick_to(m + 3);
        @(negedge clk);
        chk("step_entry_state", int'(state_o), 1);
        chk("run_instr_cnt_wrap", int'(instr_cnt_o), exp_cnt);

        // STEP: bounce 1-0-1 shorter than the debounce window, then hold.
        np = $urandom_range(2, 3);
        for (int p = 0; p < np; p++) begin
            step_btn_i = 1'b1;
            tick_to(cyc + $urandom_range(1, DB - 1));
            step_btn_i = 1'b0;
            tick_to(cyc + $urandom_range(1, 3));
            step_btn_i = 1'b1;
            r = cyc;
            push_en(r + DB + 3);
            tick_to(r + 40);
            step_btn_i = 1'b0;
            tick_to(cyc + 20);
        end
        @(negedge clk);
        chk("step_state_hold", int'(state_o), 1);
        chk("step_instr_cnt", int'(instr_cnt_o), exp_cnt);

        // FAST then break: enables every cycle until the cycle after brk_i.
        n = cyc;
        mode_i = 2'b11;
        len = $urandom_range(5, 15);
        b = n + 3 + len;
        for (int x = n + 4; x <= b; x++) push_en(x);
        tick_to(b);
        brk_i = 1'b1;
        tick_to(b + 1);
        brk_i = 1'b0;
        @(negedge clk);
        chk("brk_state", int'(state_o), 3);
        chk("brk_cpu_en", int'(cpu_en_o), 0);
        tick_to(cyc + 2);
        mode_i = 2'b10;
        tick_to(cyc + 10);
        @(negedge clk);
        chk("brk_sticky_in_run", int'(state_o), 3);
        h = cyc;
        mode_i = 2'b00;
        tick_to(h + 2);
        @(negedge clk);
        chk("brk_exit_before", int'(state_o), 3);
        tick_to(h + 3);
        @(negedge clk);
        chk("brk_exit_halt", int'(state_o), 0);

        // RUN with brk_i coinciding with tick_o: the pending enable is suppressed.
        tick_to(cyc + 3);
        n = cyc;
        mode_i = 2'b10;
        e = n + 3;
        k_pulses = $urandom_range(1, 3);
        for (int k = 1; k <= k_pulses; k++) push_en(e + 1 + TD * k);
        t = e + TD * (k_pulses + 1);
        tick_to(t);
        @(negedge clk);
        chk("brk_tick_coincide", int'(tick_o), 1);
        brk_i = 1'b1;
        tick_to(t + 1);
        brk_i = 1'b0;
        @(negedge clk);
        chk("brk_tick_state", int'(state_o), 3);
        tick_to(cyc + 3);
        @(negedge clk);
        chk("brk_tick_instr_cnt", int'(instr_cnt_o), exp_cnt);
        mode_i = 2'b00;
        tick_to(cyc + 4);
        @(negedge clk);
        chk("brk_tick_exit", int'(state_o), 0);

        // Reset mid-FAST: all outputs return to reset values on the next cycle.
        n = cyc;
        mode_i = 2'b11;
        len = $urandom_range(4, 10);
        q = n + 3 + len;
        for (int x = n + 4; x <= q; x++) push_en(x);
        tick_to(q);
        reset_i = 1'b1;
        mode_i = 2'b00;
        tick_to(q + 1);
        @(negedge clk);
        chk("midrst_cpu_en", int'(cpu_en_o), 0);
        chk("midrst_tick", int'(tick_o), 0);
        chk("midrst_state", int'(state_o), 0);
        chk("midrst_instr_cnt", int'(instr_cnt_o), 0);
        exp_cnt = 0;
        tick_to(q + 2);
        reset_i = 1'b0;
        tick_to(cyc + 8);
        @(negedge clk);
        chk("postrst_halt", int'(state_o), 0);

        // Re-apply FAST; enables stop once the synchronized mode leaves FAST.
        n = cyc;
        mode_i = 2'b11;
        len = $urandom_range(3, 8);
        m = n + 1 + len;
        for (int x = n + 4; x <= m + 2; x++) push_en(x);
        tick_to(m);
        mode_i = 2'b00;
        tick_to(m + 6);
        @(negedge clk);
        chk("refast_state", int'(state_o), 0);
        chk("refast_instr_cnt", int'(instr_cnt_o), exp_cnt);

        tick_to(cyc + 5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
